line_drawer_param: RTL
======================

# line_drawer_param

Parametrised Bresenham line drawer that replaces the fixed-width control/data line drawer pair with one self-contained block. Coordinate and colour widths are set by parameters. Endpoint latching is governed by a start/busy/done handshake. Pixel output uses a valid/ready handshake so a framebuffer writer, VGA adapter or bitmap model can stall it. It sits between the drawing sequencer and the pixel sink (VGA adapter or `vga_bmp` in simulation).

## Interface
- X_W, 9, x coordinate width (320-wide screen)
- Y_W, 8, y coordinate width (240-high screen)
- COLOUR_W, 3, colour width
- SCREEN_W, 320, clip limit in x (used only with clipping compiled in)
- SCREEN_H, 240, clip limit in y (used only with clipping compiled in)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a line; sampled only in IDLE
- x0, x1  in  X_W  endpoint x; latched when start is accepted
- y0, y1  in  Y_W  endpoint y; latched when start is accepted
- colour_in  in  COLOUR_W  colour; latched when start is accepted
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle pulse after the last point
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- colour_out  out  COLOUR_W  pixel colour
- plot  out  1  pixel valid
- plot_ready  in  1  sink accepts pixel when plot && plot_ready

## Operation
- Internal coordinate width CW = max(X_W, Y_W). Signed error register is CW+2 bits. ystep is ±1.
- States: IDLE → STEEP → ORDER → INIT → DRAW → DONE → IDLE.
- IDLE: if start, latch endpoints and colour, then go to STEEP.
- STEEP: steep = |y1−y0| > |x1−x0| (ties are not steep); if steep, swap x↔y on both endpoints.
- ORDER: if x0 > x1, swap endpoint 0 with endpoint 1.
- INIT:
  - dx = x1−x0; dy = |y1−y0|
  - error = −(dx >> 1)
  - ystep = +1 if y0 < y1, else −1
  - x = x0; y = y0
- DRAW: present (steep ? (y,x) : (x,y)) with plot=1.
  - On acceptance: if x == x1, go to DONE.
  - Otherwise x += 1 and error += dy; if the new error > 0, then y += ystep and error −= dx.
  - Points emitted = dx+1.
- DONE: done=1, busy=0, plot=0; go to IDLE. If start is still high in IDLE, the next line begins, so a held start redraws continuously with freshly latched inputs.
- start while busy is ignored. Input changes after latching have no effect.
- Degenerate line (x0,y0)==(x1,y1): exactly one point is emitted.

## Timing
- Reset values: busy=0, done=0, plot=0, x_out=0, y_out=0, colour_out=0; state=IDLE. Reset mid-line aborts immediately, with no done pulse.
- start sampled at edge T gives busy=1 from T+1 and first plot=1 at T+4.
- With plot_ready held high: one point per cycle, last point at T+4+dx, done at T+5+dx, ready for a new start at T+6+dx.
- plot_ready low: x_out, y_out, colour_out and plot hold stable and no state advances. plot never drops while a point is unaccepted.
- Outputs are registered; no combinational path from plot_ready to plot.

## Configuration
- LDA_CLIP_EN defined:
  - A point with x ≥ SCREEN_W or y ≥ SCREEN_H is not presented. plot stays 0 for that iteration and the iteration advances in one cycle regardless of plot_ready.
  - done timing counts all dx+1 iterations.
- LDA_CLIP_EN undefined: every point is presented. Coordinates are truncated to X_W/Y_W. SCREEN_W and SCREEN_H are ignored.

## Test plan
- (0,0)→(20,15), colour 3'b110, plot_ready=1 → 21 points, first (0,0), last (20,15), one point per cycle; done exactly 1 cycle at T+25.
- (20,15)→(15,30) (steep, reversed x) → 16 points, y from 15 to 30 monotonic, first (20,15), last (15,30), each y appears exactly once.
- (5,5)→(5,5) → exactly 1 point (5,5), done at T+5; start held high → line redrawn, busy rises again at T+7.
- (0,0)→(3,0) with plot_ready low for 3 cycles at the second point → (1,0) held stable with plot=1 for 4 cycles; total 4 points, no duplicates.
- LDA_CLIP_EN, SCREEN_W=320: (310,0)→(330,0) → 10 points x=310..319 with plot=1, then 11 cycles of plot=0; done at T+25.
- rst asserted during DRAW of (0,0)→(20,15) → all outputs 0 asynchronously, no done pulse; a fresh start afterwards draws the full 21 points.

Source files
------------

// File: rtl/line_drawer_param_if.sv
// line_drawer_param_if: bundle of handshake and pixel signals for line_drawer_param.
//   master : drawing sequencer / pixel sink side (drives start, endpoints, colour_in, plot_ready)
//   slave  : line drawer side (drives busy, done, x_out, y_out, colour_out, plot)
// Signals:
//   start       request a line (sampled only while the drawer is idle)
//   x0, x1      endpoint x coordinates
//   y0, y1      endpoint y coordinates
//   colour_in   line colour
//   busy        drawer occupied with a line
//   done        one-cycle pulse after the last point
//   x_out/y_out pixel coordinates
//   colour_out  pixel colour
//   plot        pixel valid
//   plot_ready  sink accepts the pixel when plot && plot_ready
interface line_drawer_param_if #(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 3
);
  logic                start;
  logic [X_W-1:0]      x0;
  logic [X_W-1:0]      x1;
  logic [Y_W-1:0]      y0;
  logic [Y_W-1:0]      y1;
  logic [COLOUR_W-1:0] colour_in;
  logic                busy;
  logic                done;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;
  logic                plot_ready;

  modport master (
    output start, x0, x1, y0, y1, colour_in, plot_ready,
    input  busy, done, x_out, y_out, colour_out, plot
  );

  modport slave (
    input  start, x0, x1, y0, y1, colour_in, plot_ready,
    output busy, done, x_out, y_out, colour_out, plot
  );
endinterface

// File: rtl/line_drawer_param.sv
// line_drawer_param: parametrised Bresenham line drawer.
// Latches two endpoints and a colour on start, then emits dx+1 pixels through a
// valid/ready (plot/plot_ready) handshake, one per cycle when the sink is ready.
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   io_bus  line_drawer_param_if.slave (start/busy/done, endpoints, pixel stream)
// Parameters: X_W, Y_W, COLOUR_W widths; SCREEN_W/SCREEN_H clip limits.
// Build option: define LDA_CLIP_EN to suppress points with x >= SCREEN_W or
// y >= SCREEN_H (such iterations take one cycle with plot low). Without it every
// point is presented, truncated to X_W/Y_W, and SCREEN_W/SCREEN_H are unused.
module line_drawer_param #(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240
) (
  input logic                clk,
  input logic                rst,
  line_drawer_param_if.slave io_bus
);

  localparam int unsigned CW = (X_W > Y_W) ? X_W : Y_W;
  localparam int unsigned EW = CW + 2;

  typedef enum logic [2:0] {StIdle, StSteep, StOrder, StInit, StDraw, StDone} state_e;

  state_e               r_state;
  logic [CW-1:0]        r_x0, r_y0, r_x1, r_y1;
  logic [COLOUR_W-1:0]  r_colour;
  logic                 r_steep;
  logic [CW-1:0]        r_dx, r_dy;
  logic signed [EW-1:0] r_err;
  logic                 r_ystep_neg;
  logic [CW-1:0]        r_x, r_y;
  logic                 r_busy, r_done, r_plot;
  logic [X_W-1:0]       r_x_out;
  logic [Y_W-1:0]       r_y_out;
  logic [COLOUR_W-1:0]  r_colour_out;

  logic [CW-1:0]        w_adx, w_ady, w_dx;
  logic signed [EW-1:0] w_err_inc, w_err_nxt;
  logic                 w_step_y;
  logic [CW-1:0]        w_x_nxt, w_y_nxt;
  logic [CW-1:0]        w_pt_x, w_pt_y, w_sx, w_sy;
  logic                 w_vis;
  logic                 w_adv;

  assign w_adx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_ady = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
  // Valid only after ORDER, where x1 >= x0 is guaranteed.
  assign w_dx  = r_x1 - r_x0;

  assign w_err_inc = r_err + $signed({2'b00, r_dy});
  assign w_step_y  = !w_err_inc[EW-1] && (w_err_inc != '0);
  assign w_err_nxt = w_step_y ? (w_err_inc - $signed({2'b00, r_dx})) : w_err_inc;
  assign w_x_nxt   = r_x + 1'b1;
  assign w_y_nxt   = !w_step_y ? r_y : (r_ystep_neg ? (r_y - 1'b1) : (r_y + 1'b1));

  // Point to load into the output registers: the first point in INIT, else the next one.
  always_comb begin
    w_pt_x = w_x_nxt;
    w_pt_y = w_y_nxt;
    if (r_state == StInit) begin
      w_pt_x = r_x0;
      w_pt_y = r_y0;
    end
  end

  // Undo the steep swap for presentation.
  assign w_sx = r_steep ? w_pt_y : w_pt_x;
  assign w_sy = r_steep ? w_pt_x : w_pt_y;

`ifdef LDA_CLIP_EN
  assign w_vis = (32'(w_sx) < SCREEN_W) && (32'(w_sy) < SCREEN_H);
`else
  logic w_unused_screen;
  assign w_unused_screen = (SCREEN_W == 0) || (SCREEN_H == 0);
  assign w_vis = 1'b1;
`endif

  // A hidden (clipped) point needs no acceptance.
  assign w_adv = !r_plot || io_bus.plot_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_x0         <= '0;
      r_y0         <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_colour     <= '0;
      r_steep      <= 1'b0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_err        <= '0;
      r_ystep_neg  <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_plot       <= 1'b0;
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_colour_out <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_x0     <= CW'(io_bus.x0);
            r_y0     <= CW'(io_bus.y0);
            r_x1     <= CW'(io_bus.x1);
            r_y1     <= CW'(io_bus.y1);
            r_colour <= io_bus.colour_in;
            r_busy   <= 1'b1;
            r_state  <= StSteep;
          end
        end
        StSteep: begin
          r_steep <= (w_ady > w_adx);
          if (w_ady > w_adx) begin
            r_x0 <= r_y0;
            r_y0 <= r_x0;
            r_x1 <= r_y1;
            r_y1 <= r_x1;
          end
          r_state <= StOrder;
        end
        StOrder: begin
          if (r_x0 > r_x1) begin
            r_x0 <= r_x1;
            r_y0 <= r_y1;
            r_x1 <= r_x0;
            r_y1 <= r_y0;
          end
          r_state <= StInit;
        end
        StInit: begin
          r_dx         <= w_dx;
          r_dy         <= w_ady;
          r_err        <= -$signed({3'b000, w_dx[CW-1:1]});
          r_ystep_neg  <= !(r_y0 < r_y1);
          r_x          <= r_x0;
          r_y          <= r_y0;
          r_x_out      <= w_sx[X_W-1:0];
          r_y_out      <= w_sy[Y_W-1:0];
          r_colour_out <= r_colour;
          r_plot       <= w_vis;
          r_state      <= StDraw;
        end
        StDraw: begin
          if (w_adv) begin
            if (r_x == r_x1) begin
              r_plot  <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StDone;
            end else begin
              r_x     <= w_x_nxt;
              r_y     <= w_y_nxt;
              r_err   <= w_err_nxt;
              r_x_out <= w_sx[X_W-1:0];
              r_y_out <= w_sy[Y_W-1:0];
              r_plot  <= w_vis;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.plot       = r_plot;
  assign io_bus.x_out      = r_x_out;
  assign io_bus.y_out      = r_y_out;
  assign io_bus.colour_out = r_colour_out;

endmodule
